// File: rtl/fa_8_bit_pkg.sv
// Shared constants for the registered byte adder.
package fa_8_bit_pkg;
  localparam int DATA_W = 8;
  localparam int STAGES = 1;
  localparam logic [DATA_W-1:0] SUM_RST = 8'h00;
endpackage

// File: rtl/fa_8_bit_fa_1_bit.sv
// One-bit full adder cell; eight of these form the ripple chain.
module fa_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ cin;
  assign co = (a & b) | (cin & p);
endmodule

// File: rtl/fa_8_bit.sv
// Registered 8-bit ripple-carry adder: {co_bit_8, sum} = a + b + cin, one cycle latency.
module fa_8_bit
  import fa_8_bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  output logic [DATA_W-1:0] sum,
  output logic              co_bit_8,
  output logic              ovf
);
  logic [DATA_W:0]   c;
  logic [DATA_W-1:0] s;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_q;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      fa_1_bit u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .cin(c[gi]),
        .s  (s[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  // Result registers load only on accepted operands, otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= SUM_RST;
      co_bit_8 <= 1'b0;
      ovf      <= 1'b0;
    end else if (in_valid) begin
      sum      <= s;
      co_bit_8 <= c[DATA_W];
      ovf      <= c[DATA_W-1] ^ c[DATA_W];
    end
  end

  assign vld_pipe = {vld_q, in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fa_8_bit.sv
// Randomized and directed bench for fa_8_bit against an arithmetic reference model.
module tb_fa_8_bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic [7:0] sum;
  logic       co_bit_8;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  // expected outputs for the upcoming sample point
  logic       e_vld = 1'b0;
  logic [7:0] e_sum = '0;
  logic       e_co  = 1'b0;
  logic       e_ovf = 1'b0;

  fa_8_bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
    .co_bit_8 (co_bit_8),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Signed overflow: same-sign operands giving a result of the other sign.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                       output logic [7:0] rs, output logic rc, output logic ro);
    int unsigned r;
    r  = int'(ma) + int'(mb) + int'(mc);
    rs = r[7:0];
    rc = r[8];
    ro = (ma[7] == mb[7]) && (rs[7] != ma[7]);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 16'(out_valid), 16'(e_vld));
    chk({tag, ".sum"},       16'(sum),       16'(e_sum));
    chk({tag, ".co"},        16'(co_bit_8),  16'(e_co));
    chk({tag, ".ovf"},       16'(ovf),       16'(e_ovf));
  endtask

  // At each falling edge: check what the previous rising edge produced, then drive the next beat.
  task automatic step(input string tag, input logic v, input logic [7:0] sa,
                      input logic [7:0] sb, input logic sc);
    @(negedge clk);
    check_outs(tag);
    in_valid = v; a = sa; b = sb; cin = sc;
    e_vld = v;
    if (v) model(sa, sb, sc, e_sum, e_co, e_ovf);
  endtask

  task automatic reset_expect();
    e_vld = 1'b0; e_sum = 8'h00; e_co = 1'b0; e_ovf = 1'b0;
  endtask

  initial begin
    logic [7:0] corner [4];
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;

    // power-on reset, checked before any clock activity matters
    #1 rst_n = 1'b0;
    #1 reset_expect();
    check_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases from the datasheet
    step("idle",  1'b1, 8'h01, 8'h01, 1'b0);
    step("a11",   1'b1, 8'h03, 8'h01, 1'b0);
    step("a31",   1'b1, 8'hFF, 8'h01, 1'b0);
    step("wrap",  1'b1, 8'h7F, 8'h7F, 1'b0);
    step("sovf",  1'b1, 8'h0F, 8'h0F, 1'b1);
    step("cin",   1'b1, 8'hFF, 8'hFF, 1'b1);
    step("max",   1'b0, 8'h12, 8'h34, 1'b0);
    step("hold0", 1'b0, 8'h55, 8'hAA, 1'b1);

    // streaming: four back-to-back beats then idle with noise on the operands
    step("s0", 1'b1, 8'h10, 8'h20, 1'b0);
    step("s1", 1'b1, 8'h80, 8'h80, 1'b0);
    step("s2", 1'b1, 8'hC0, 8'h40, 1'b1);
    step("s3", 1'b1, 8'h64, 8'h1C, 1'b1);
    for (int i = 0; i < 4; i++)
      step("shold", 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));

    // sign-boundary corners
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 2; k++)
          step("corner", 1'b1, corner[i], corner[j], 1'(k));

    // reset while a result is being presented: must clear immediately, no pulse
    step("pre_rst", 1'b1, 8'hFE, 8'h03, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_expect();
    check_outs("midrst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step("post_rst", 1'b0, 8'h00, 8'h00, 1'b0);

    // first accept after release
    step("first", 1'b1, 8'h9C, 8'h9C, 1'b0);

    // random mix of valid and idle beats
    for (int i = 0; i < 4000; i++)
      step("rand", 1'(($urandom % 4) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    step("tail", 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check_outs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
